uart_packet_framer: RTL and testbench

UART_PACKET_FRAMER -- requirements
Module: uart_packet_framer

---
 rtl/uart_packet_framer_pkg.sv | 15 +
 rtl/uart_packet_framer_packet_output_reg.sv | 44 ++++
 rtl/uart_packet_framer.sv | 96 +++++++++
 tb/tb_uart_packet_framer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_packet_framer_pkg.sv
// Shared definitions for the UART packet framer: parser states and default
// frame constants.
package uart_packet_framer_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_MAGIC = 2'd0,
    ST_LEN_HI     = 2'd1,
    ST_LEN_LO     = 2'd2,
    ST_PAYLOAD    = 2'd3
  } state_e;

  localparam logic [7:0] DEFAULT_MAGIC   = 8'h51;
  localparam int         DEFAULT_MAX_LEN = 1024;

endpackage

// File: rtl/uart_packet_framer_packet_output_reg.sv
// One-entry holding register between the header parser and a ready/valid sink.
// A load that finds the entry full and not draining is refused and flagged.
module packet_output_reg (
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       load_last,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data,
  output logic       last,
  output logic       drop
);

  logic valid_reg;
  logic last_reg;
  logic [7:0] data_reg;
  logic can_load;

  // The entry can take a new byte when empty or when it is emptying this cycle.
  assign can_load = !valid_reg || ready;
  assign drop     = load && !can_load;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      data_reg  <= 8'h00;
    end else if (load && can_load) begin
      valid_reg <= 1'b1;
      last_reg  <= load_last;
      data_reg  <= load_data;
    end else if (valid_reg && ready) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;
  assign last  = last_reg;

endmodule

// File: rtl/uart_packet_framer.sv
// Parses MAGIC / LEN_HI / LEN_LO / payload frames from a byte stream and
// forwards payload bytes through a one-entry output register.
module uart_packet_framer
  import uart_packet_framer_pkg::*;
#(
  parameter logic [7:0] MAGIC   = DEFAULT_MAGIC,
  parameter int         MAX_LEN = DEFAULT_MAX_LEN
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       uart_valid,
  input  logic [7:0] uart_data,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data,
  output logic       last,
  output logic       overflow,
  output logic       length_error
);

  // Lengths above 16 bits cannot occur on the wire, so clamp the limit.
  localparam int         MAX_CLAMP = (MAX_LEN > 65535) ? 65535 : MAX_LEN;
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_CLAMP);

  state_e      state_reg;
  logic [15:8] length_reg;
  logic [15:0] remaining_reg;
  logic        overflow_reg;
  logic        length_error_reg;

  logic [15:0] full_len;
  logic        load;
  logic        load_last;
  logic        drop;

  assign full_len  = {length_reg, uart_data};
  assign load      = uart_valid && (state_reg == ST_PAYLOAD);
  assign load_last = (remaining_reg == 16'd1);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg        <= ST_WAIT_MAGIC;
      length_reg       <= 8'h00;
      remaining_reg    <= 16'd0;
      overflow_reg     <= 1'b0;
      length_error_reg <= 1'b0;
    end else begin
      length_error_reg <= 1'b0;
      if (drop) overflow_reg <= 1'b1;
      if (uart_valid) begin
        case (state_reg)
          ST_WAIT_MAGIC: begin
            if (uart_data == MAGIC) state_reg <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            length_reg <= uart_data;
            state_reg  <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            if (full_len == 16'd0) begin
              state_reg <= ST_WAIT_MAGIC;
            end else if (full_len > MAX_LEN_W) begin
              length_error_reg <= 1'b1;
              state_reg        <= ST_WAIT_MAGIC;
            end else begin
              remaining_reg <= full_len;
              state_reg     <= ST_PAYLOAD;
            end
          end
          default: begin
            // Payload bytes count down even when dropped, keeping frame sync.
            if (remaining_reg != 16'd0) remaining_reg <= remaining_reg - 16'd1;
            if (remaining_reg <= 16'd1) state_reg <= ST_WAIT_MAGIC;
          end
        endcase
      end
    end
  end

  packet_output_reg u_output_reg (
    .clock     (clock),
    .clear     (clear),
    .load      (load),
    .load_data (uart_data),
    .load_last (load_last),
    .ready     (ready),
    .valid     (valid),
    .data      (data),
    .last      (last),
    .drop      (drop)
  );

  assign overflow     = overflow_reg;
  assign length_error = length_error_reg;

endmodule

// File: tb/tb_uart_packet_framer.sv
// Directed-vector bench for uart_packet_framer with hand-computed expectations.
module tb_uart_packet_framer;

  logic       clock;
  logic       clear;
  logic       uart_valid;
  logic [7:0] uart_data;
  logic       ready;
  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       overflow;
  logic       length_error;

  int errors = 0;
  int checks = 0;

  uart_packet_framer #(.MAGIC(8'h51), .MAX_LEN(1024)) dut (
    .clock        (clock),
    .clear        (clear),
    .uart_valid   (uart_valid),
    .uart_data    (uart_data),
    .ready        (ready),
    .valid        (valid),
    .data         (data),
    .last         (last),
    .overflow     (overflow),
    .length_error (length_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the byte was sampled.
  task automatic send_byte(input logic [7:0] b);
    uart_valid = 1'b1;
    uart_data  = b;
    @(negedge clock);
    uart_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clock);
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic l);
    check({tag, ".valid"}, {15'd0, valid}, 16'd1);
    check({tag, ".data"},  {8'd0, data},   {8'd0, d});
    check({tag, ".last"},  {15'd0, last},  {15'd0, l});
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".valid"}, {15'd0, valid}, 16'd0);
  endtask

  initial begin
    clear      = 1'b0;
    ready      = 1'b1;
    uart_valid = 1'b0;
    uart_data  = 8'h00;
    repeat (2) @(negedge clock);

    // Reset state
    check("rst.valid",  {15'd0, valid}, 16'd0);
    check("rst.data",   {8'd0, data}, 16'h0000);
    check("rst.last",   {15'd0, last}, 16'd0);
    check("rst.ovf",    {15'd0, overflow}, 16'd0);
    check("rst.lenerr", {15'd0, length_error}, 16'd0);
    clear = 1'b1;
    idle();

    // Basic 3-byte frame
    send_byte(8'h51); check_empty("f1.magic");
    send_byte(8'h00);
    send_byte(8'h03); check_empty("f1.len");
    send_byte(8'hAA); check_out("f1.b0", 8'hAA, 1'b0);
    send_byte(8'hBB); check_out("f1.b1", 8'hBB, 1'b0);
    send_byte(8'hCC); check_out("f1.b2", 8'hCC, 1'b1);
    idle();           check_empty("f1.drain");
    check("f1.ovf", {15'd0, overflow}, 16'd0);

    // Leading garbage, MAGIC value as payload
    send_byte(8'h00); check_empty("f2.junk0");
    send_byte(8'h7F); check_empty("f2.junk1");
    send_byte(8'h51);
    send_byte(8'h00);
    send_byte(8'h01); check_empty("f2.hdr");
    send_byte(8'h51); check_out("f2.b0", 8'h51, 1'b1);
    idle();           check_empty("f2.drain");

    // Zero-length frame followed by a real one
    send_byte(8'h51);
    send_byte(8'h00);
    send_byte(8'h00); check_empty("f3.zero");
    idle();           check_empty("f3.zero2");
    send_byte(8'h51);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h5A); check_out("f3.b0", 8'h5A, 1'b1);
    idle();

    // Length 1025 exceeds MAX_LEN
    send_byte(8'h51);
    send_byte(8'h04);
    check("f4.lenerr.pre", {15'd0, length_error}, 16'd0);
    send_byte(8'h01);
    check("f4.lenerr", {15'd0, length_error}, 16'd1);
    check_empty("f4.noout");
    idle();
    check("f4.lenerr.pulse", {15'd0, length_error}, 16'd0);
    send_byte(8'h51);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h77); check_out("f4.b0", 8'h77, 1'b1);
    idle();

    // Length exactly MAX_LEN is accepted
    send_byte(8'h51);
    send_byte(8'h04);
    send_byte(8'h00);
    check("f5.lenerr", {15'd0, length_error}, 16'd0);
    for (int i = 0; i < 1024; i++) begin
      send_byte(i[7:0]);
      if (i == 0)    check_out("f5.first", 8'h00, 1'b0);
      if (i == 1022) check_out("f5.penult", 8'hFE, 1'b0);
    end
    check_out("f5.final", 8'hFF, 1'b1);
    idle();           check_empty("f5.drain");

    // Backpressure: second byte dropped
    ready = 1'b0;
    send_byte(8'h51);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11); check_out("f6.b0", 8'h11, 1'b0);
    check("f6.ovf.pre", {15'd0, overflow}, 16'd0);
    send_byte(8'h22); check_out("f6.hold", 8'h11, 1'b0);
    check("f6.ovf", {15'd0, overflow}, 16'd1);
    idle(); idle();   check_out("f6.hold2", 8'h11, 1'b0);
    ready = 1'b1;
    idle();           check_empty("f6.drained");
    check("f6.ovf.sticky", {15'd0, overflow}, 16'd1);
    send_byte(8'h51);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h33); check_out("f6.resync", 8'h33, 1'b1);
    idle();

    // Reset mid-packet
    send_byte(8'h51);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h02); check_out("f7.pre", 8'h02, 1'b0);
    ready = 1'b0;
    clear = 1'b0;
    #1;
    check("f7.rst.valid", {15'd0, valid}, 16'd0);
    check("f7.rst.data",  {8'd0, data}, 16'h0000);
    check("f7.rst.ovf",   {15'd0, overflow}, 16'd0);
    @(negedge clock);
    clear = 1'b1;
    ready = 1'b1;
    idle();
    send_byte(8'h51);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h99); check_out("f7.b0", 8'h99, 1'b1);
    idle();           check_empty("f7.drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
